// File: rtl/msx_bus_initiator_pkg.sv
// msx_bus_initiator_pkg: shared types for the MSX slot-bus initiator.
//   state_e   - bus-cycle FSM states (IDLE/T1/T2/TW/T3/DONE)
//   cmd_t     - latched command (write, io, slot, addr, wdata)
//   IDLE_DATA - value an undriven MSX data bus reads as
package msx_bus_initiator_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_T1,
        ST_T2,
        ST_TW,
        ST_T3,
        ST_DONE
    } state_e;

    typedef struct packed {
        logic        write;
        logic        io;
        logic        slot;
        logic [15:0] addr;
        logic [7:0]  wdata;
    } cmd_t;

    localparam logic [7:0] IDLE_DATA = 8'hFF;

endpackage

// File: rtl/msx_bus_initiator_if.sv
// msx_bus_initiator_if: command/response handshake plus MSX slot-bus signals.
//   master - initiator view (drives cmd_ready, rsp_*, bus strobes/address/data)
//   slave  - requester + responder view (drives cmd_*, bus_d_in, bus_wait_n)
interface msx_bus_initiator_if;

    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic        cmd_io;
    logic        cmd_slot;
    logic [15:0] cmd_addr;
    logic [7:0]  cmd_wdata;

    logic        rsp_valid;
    logic [7:0]  rsp_rdata;
    logic        rsp_timeout;

    logic [15:0] bus_a;
    logic [7:0]  bus_d_out;
    logic        bus_d_oe;
    logic [7:0]  bus_d_in;
    logic        bus_mreq_n;
    logic        bus_iorq_n;
    logic        bus_rd_n;
    logic        bus_wr_n;
    logic        bus_sltsl_n;
    logic        bus_wait_n;

    modport master (
        input  cmd_valid, cmd_write, cmd_io, cmd_slot, cmd_addr, cmd_wdata,
        output cmd_ready,
        output rsp_valid, rsp_rdata, rsp_timeout,
        output bus_a, bus_d_out, bus_d_oe,
        output bus_mreq_n, bus_iorq_n, bus_rd_n, bus_wr_n, bus_sltsl_n,
        input  bus_d_in, bus_wait_n
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_io, cmd_slot, cmd_addr, cmd_wdata,
        input  cmd_ready,
        input  rsp_valid, rsp_rdata, rsp_timeout,
        input  bus_a, bus_d_out, bus_d_oe,
        input  bus_mreq_n, bus_iorq_n, bus_rd_n, bus_wr_n, bus_sltsl_n,
        output bus_d_in, bus_wait_n
    );

endinterface

// File: rtl/msx_tstate_timer.sv
// msx_tstate_timer: counts CLK cycles within one Z80 T-state.
//   clk_i, rst_i - clock, synchronous active-high reset
//   restart_i    - FSM is changing state this clock; next T-state starts at 0
//   last_o       - current clock is the last one of the T-state
module msx_tstate_timer #(
    parameter int unsigned TSTATE_CLKS = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic restart_i,
    output logic last_o
);

    localparam int unsigned CW = (TSTATE_CLKS > 1) ? $clog2(TSTATE_CLKS) : 1;
    localparam logic [CW-1:0] LAST = CW'(TSTATE_CLKS - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign last_o = (cnt_q == LAST);

    // Wrapping on last_o lets a state that repeats (TW->TW) start a fresh T-state.
    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (restart_i || last_o) cnt_d = '0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

endmodule

// File: rtl/msx_bus_initiator.sv
// msx_bus_initiator: turns single commands into Z80-timed MSX slot-bus cycles.
//   CLK, RESET - clock, synchronous active-high reset
//   bus        - msx_bus_initiator_if.master: cmd handshake, response, bus pins
// Optional: define MSX_BUS_INITIATOR_TIMEOUT_EN to abort a cycle after
// TIMEOUT_TS consecutive wait T-states (rsp_timeout=1, read data 8'hFF).
module msx_bus_initiator
    import msx_bus_initiator_pkg::*;
#(
    parameter int unsigned TSTATE_CLKS = 4,
    parameter int unsigned TIMEOUT_TS  = 256
) (
    input  logic                 CLK,
    input  logic                 RESET,
    msx_bus_initiator_if.master  bus
);

    state_e     state_q, state_d;
    cmd_t       cmd_q;
    logic [7:0] rdata_q;
    logic       ts_last;
    logic       accept;
    logic       timeout_hit;
    logic       rsp_to;

    msx_tstate_timer #(.TSTATE_CLKS(TSTATE_CLKS)) u_timer (
        .clk_i     (CLK),
        .rst_i     (RESET),
        .restart_i (state_d != state_q),
        .last_o    (ts_last)
    );

    assign accept = (state_q == ST_IDLE) && bus.cmd_valid;

`ifdef MSX_BUS_INITIATOR_TIMEOUT_EN
    localparam int unsigned TWW = $clog2(TIMEOUT_TS + 1);

    logic [TWW-1:0] tw_cnt_q;
    logic           to_q;

    // tw_cnt_q = completed TW states of the current wait stretch.
    assign timeout_hit = (state_q == ST_TW) && ts_last && !bus.bus_wait_n &&
                         (tw_cnt_q == TWW'(TIMEOUT_TS - 1));
    assign rsp_to      = (state_q == ST_DONE) && to_q;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            tw_cnt_q <= '0;
            to_q     <= 1'b0;
        end else begin
            if (state_q != ST_TW) tw_cnt_q <= '0;
            else if (ts_last)     tw_cnt_q <= tw_cnt_q + 1'b1;
            if (accept)           to_q <= 1'b0;
            else if (timeout_hit) to_q <= 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign rsp_to      = 1'b0;
`endif

    // State register
    always_ff @(posedge CLK) begin
        if (RESET) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic; T-states advance only on their last clock.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (accept)  state_d = ST_T1;
            ST_T1:   if (ts_last) state_d = ST_T2;
            // I/O always gets one TW; memory only when WAIT_n is low.
            ST_T2:   if (ts_last) state_d = (cmd_q.io || !bus.bus_wait_n) ? ST_TW : ST_T3;
            ST_TW: begin
                if (ts_last) begin
                    if (bus.bus_wait_n) state_d = ST_T3;
                    else if (timeout_hit) state_d = ST_DONE;
                end
            end
            ST_T3:   if (ts_last) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Command latch and read data capture
    always_ff @(posedge CLK) begin
        if (RESET) begin
            cmd_q   <= '0;
            rdata_q <= '0;
        end else begin
            if (accept)
                cmd_q <= {bus.cmd_write, bus.cmd_io, bus.cmd_slot, bus.cmd_addr, bus.cmd_wdata};
            if ((state_q == ST_T3) && ts_last && !cmd_q.write)
                rdata_q <= bus.bus_d_in;
`ifdef MSX_BUS_INITIATOR_TIMEOUT_EN
            if (timeout_hit && !cmd_q.write)
                rdata_q <= IDLE_DATA;
`endif
        end
    end

    // Outputs decoded from state; address/data hold the last command.
    always_comb begin
        logic strb;
        logic in_cyc;
        strb   = (state_q == ST_T2) || (state_q == ST_TW) || (state_q == ST_T3);
        in_cyc = strb || (state_q == ST_T1);

        bus.cmd_ready   = (state_q == ST_IDLE) && !RESET;
        bus.rsp_valid   = (state_q == ST_DONE);
        bus.rsp_rdata   = rdata_q;
        bus.rsp_timeout = rsp_to;
        bus.bus_a       = cmd_q.addr;
        bus.bus_d_out   = cmd_q.wdata;
        bus.bus_d_oe    = in_cyc && cmd_q.write;
        bus.bus_mreq_n  = !(strb && !cmd_q.io);
        bus.bus_iorq_n  = !(strb && cmd_q.io);
        bus.bus_rd_n    = !(strb && !cmd_q.write);
        bus.bus_wr_n    = !(strb && cmd_q.write);
        bus.bus_sltsl_n = !(strb && !cmd_q.io && cmd_q.slot);
    end

endmodule

// File: tb/tb_msx_bus_initiator.sv
// tb_msx_bus_initiator: directed self-checking bench for msx_bus_initiator
// (TSTATE_CLKS=4, TIMEOUT_TS=4). Clock index k counts negedges after the
// accept edge, so T1 occupies k=1..4 and a plain memory cycle's DONE is k=13.
module tb_msx_bus_initiator;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    msx_bus_initiator_if bus();

    msx_bus_initiator #(.TSTATE_CLKS(4), .TIMEOUT_TS(4)) dut (
        .CLK   (clk),
        .RESET (rst),
        .bus   (bus)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
        end
    endtask

    // per-run observations
    int c_mreq, c_iorq, c_rd, c_wr, c_slt, c_oe, vld_k, vld_n, abad;
    logic [7:0] r_data;
    logic       r_to;

    task automatic run(input logic wr, input logic io, input logic slt,
                       input logic [15:0] a, input logic [7:0] wd,
                       input logic [7:0] rd_resp, input int waitclk);
        int lowcnt;
        c_mreq = 0; c_iorq = 0; c_rd = 0; c_wr = 0; c_slt = 0; c_oe = 0;
        vld_k = 0; vld_n = 0; abad = 0; r_data = 8'h00; r_to = 1'b0;
        @(negedge clk);
        bus.cmd_valid = 1'b1; bus.cmd_write = wr; bus.cmd_io = io;
        bus.cmd_slot = slt; bus.cmd_addr = a; bus.cmd_wdata = wd;
        bus.bus_d_in = rd_resp;
        @(posedge clk);
        for (int k = 1; k <= 200; k++) begin
            @(negedge clk);
            bus.cmd_valid = 1'b0;
            if (!bus.bus_mreq_n)  c_mreq++;
            if (!bus.bus_iorq_n)  c_iorq++;
            if (!bus.bus_rd_n)    c_rd++;
            if (!bus.bus_wr_n)    c_wr++;
            if (!bus.bus_sltsl_n) c_slt++;
            if (bus.bus_d_oe)     c_oe++;
            if ((!bus.bus_mreq_n || !bus.bus_iorq_n) && bus.bus_a != a) abad++;
            if (bus.bus_d_oe && bus.bus_d_out != wd) abad++;
            if (bus.rsp_valid) begin
                vld_n++;
                if (vld_k == 0) begin
                    vld_k  = k;
                    r_data = bus.rsp_rdata;
                    r_to   = bus.rsp_timeout;
                end
            end
            // WAIT_n low while fewer than waitclk strobe clocks have elapsed
            lowcnt = c_mreq + c_iorq;
            bus.bus_wait_n = (lowcnt > waitclk);
            if (vld_k != 0 && k >= vld_k + 2) break;
        end
        bus.bus_wait_n = 1'b1;
    endtask

    initial begin
        int v1, v2, rdy2, s2, rdy_early, vcnt;
        logic [7:0] r1, r2;
        #200000;
        $display("FAIL global_timeout act=running exp=finished");
        $fatal(1, "bench time limit");
    end

    initial begin
        int v1, v2, rdy2, s2, rdy_early, vcnt;
        logic [7:0] r1, r2;
        bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_io = 1'b0;
        bus.cmd_slot = 1'b0; bus.cmd_addr = 16'h0; bus.cmd_wdata = 8'h0;
        bus.bus_d_in = 8'h00; bus.bus_wait_n = 1'b1;

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_ready",  bus.cmd_ready, 0);
        chk("rst_strb",   {bus.bus_mreq_n, bus.bus_iorq_n, bus.bus_rd_n, bus.bus_wr_n, bus.bus_sltsl_n}, 5'h1F);
        chk("rst_oe",     bus.bus_d_oe, 0);
        chk("rst_a",      bus.bus_a, 16'h0);
        chk("rst_dout",   bus.bus_d_out, 8'h0);
        chk("rst_rdata",  bus.rsp_rdata, 8'h0);
        chk("rst_vld",    bus.rsp_valid, 0);
        chk("rst_to",     bus.rsp_timeout, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("rel_ready",  bus.cmd_ready, 1);

        // memory read, slot selected, no wait
        run(1'b0, 1'b0, 1'b1, 16'h4000, 8'h00, 8'hA5, 0);
        chk("mr_mreq",  c_mreq, 8);
        chk("mr_rd",    c_rd, 8);
        chk("mr_slt",   c_slt, 8);
        chk("mr_iorq",  c_iorq, 0);
        chk("mr_wr",    c_wr, 0);
        chk("mr_oe",    c_oe, 0);
        chk("mr_vldk",  vld_k, 13);
        chk("mr_vldn",  vld_n, 1);
        chk("mr_rdata", r_data, 8'hA5);
        chk("mr_to",    r_to, 0);
        chk("mr_abad",  abad, 0);

        // I/O write with slot bit set: SLTSL_n must stay high
        run(1'b1, 1'b1, 1'b1, 16'h0098, 8'h3C, 8'h00, 0);
        chk("iw_iorq",  c_iorq, 12);
        chk("iw_wr",    c_wr, 12);
        chk("iw_mreq",  c_mreq, 0);
        chk("iw_rd",    c_rd, 0);
        chk("iw_slt",   c_slt, 0);
        chk("iw_oe",    c_oe, 16);
        chk("iw_vldk",  vld_k, 17);
        chk("iw_abad",  abad, 0);

        // memory write, WAIT_n low for 3 T-states
        run(1'b1, 1'b0, 1'b0, 16'h8000, 8'h5A, 8'h00, 12);
        chk("mw_mreq",  c_mreq, 20);
        chk("mw_wr",    c_wr, 20);
        chk("mw_slt",   c_slt, 0);
        chk("mw_oe",    c_oe, 24);
        chk("mw_vldk",  vld_k, 25);
        chk("mw_vldn",  vld_n, 1);
        chk("mw_abad",  abad, 0);

        // I/O read with one wait T-state beyond the automatic TW
        run(1'b0, 1'b1, 1'b0, 16'h12A8, 8'h00, 8'h7E, 8);
        chk("ir_iorq",  c_iorq, 16);
        chk("ir_rd",    c_rd, 16);
        chk("ir_vldk",  vld_k, 21);
        chk("ir_rdata", r_data, 8'h7E);
        chk("ir_to",    r_to, 0);

        // back-to-back reads, cmd_valid held high
        v1 = 0; v2 = 0; rdy2 = 0; s2 = 0; rdy_early = 0; r1 = 8'h00; r2 = 8'h00;
        @(negedge clk);
        bus.cmd_valid = 1'b1; bus.cmd_write = 1'b0; bus.cmd_io = 1'b0;
        bus.cmd_slot = 1'b1; bus.cmd_addr = 16'h4001; bus.bus_d_in = 8'hC3;
        @(posedge clk);
        for (int k = 1; k <= 80; k++) begin
            @(negedge clk);
            if (v1 == 0 && bus.cmd_ready) rdy_early++;
            if (v1 != 0 && v2 == 0 && s2 == 0 && !bus.bus_mreq_n) s2 = k;
            if (v1 != 0 && rdy2 == 0 && bus.cmd_ready) rdy2 = k;
            if (rdy2 != 0 && k == rdy2 + 1) bus.cmd_valid = 1'b0;
            if (bus.rsp_valid) begin
                if (v1 == 0) begin
                    v1 = k; r1 = bus.rsp_rdata;
                    bus.bus_d_in = 8'h96; bus.cmd_addr = 16'h4002;
                end else if (v2 == 0) begin
                    v2 = k; r2 = bus.rsp_rdata;
                end
            end
            if (v2 != 0 && k >= v2 + 2) break;
        end
        bus.cmd_valid = 1'b0;
        chk("bb_v1",     v1, 13);
        chk("bb_r1",     r1, 8'hC3);
        chk("bb_noq",    rdy_early, 0);
        chk("bb_rdy2",   rdy2, 14);
        chk("bb_s2",     s2, 19);
        chk("bb_v2",     v2, 27);
        chk("bb_r2",     r2, 8'h96);

        // reset asserted during T2 of a read
        @(negedge clk);
        bus.cmd_valid = 1'b1; bus.cmd_write = 1'b0; bus.cmd_io = 1'b0;
        bus.cmd_slot = 1'b1; bus.cmd_addr = 16'h4003;
        @(posedge clk);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            bus.cmd_valid = 1'b0;
        end
        chk("rm_t2_mreq", bus.bus_mreq_n, 0);
        rst = 1'b1;
        @(negedge clk);
        chk("rm_strb",  {bus.bus_mreq_n, bus.bus_iorq_n, bus.bus_rd_n, bus.bus_wr_n, bus.bus_sltsl_n}, 5'h1F);
        chk("rm_oe",    bus.bus_d_oe, 0);
        chk("rm_vld",   bus.rsp_valid, 0);
        chk("rm_ready", bus.cmd_ready, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("rm_ready_rel", bus.cmd_ready, 1);
        vcnt = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (bus.rsp_valid) vcnt++;
        end
        chk("rm_novld", vcnt, 0);

`ifdef MSX_BUS_INITIATOR_TIMEOUT_EN
        // WAIT_n stuck low: four TW states then abort
        run(1'b0, 1'b0, 1'b1, 16'h0001, 8'h00, 8'h11, 100000);
        chk("to_mreq",  c_mreq, 20);
        chk("to_vldk",  vld_k, 25);
        chk("to_vldn",  vld_n, 1);
        chk("to_flag",  r_to, 1);
        chk("to_rdata", r_data, 8'hFF);
        chk("to_strb",  {bus.bus_mreq_n, bus.bus_iorq_n, bus.bus_rd_n, bus.bus_wr_n, bus.bus_sltsl_n}, 5'h1F);
`endif

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
